// File: rtl/serial_deframer5_if.sv
// Bundle of serial-in and parallel-word-out signals for serial_deframer5.
// The master side drives the serial line; the slave side is the deframer.
interface serial_deframer5_if;
  logic       serial_input;
  logic       sample_enable;
  logic [4:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       frame_error;
  logic       busy;
  logic [3:0] frame_count;

  modport master (
    output serial_input, sample_enable,
    input  data_out, data_valid, parity_error, frame_error, busy, frame_count
  );

  modport slave (
    input  serial_input, sample_enable,
    output data_out, data_valid, parity_error, frame_error, busy, frame_count
  );
endinterface

// File: rtl/serial_deframer5.sv
// Receives start + 5 data bits (LSB first) + even parity + stop from a sampled
// serial line and presents each word in parallel with error flags and a good-frame count.
module serial_deframer5 (
  input  logic                clockpulse,
  input  logic                clear,
  serial_deframer5_if.slave   bus
);
  // state   | meaning
  // S_IDLE  | waiting for a sampled 1 (start bit)
  // S_DATA  | collecting data bits 0..4
  // S_PARITY| capturing the parity bit
  // S_STOP  | sampling the stop bit and completing the frame
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [4:0] r_shift;
  logic       r_par;
  logic [4:0] r_data_out;
  logic       r_valid;
  logic       r_perr;
  logic       r_ferr;
  logic       r_busy;
  logic [3:0] r_count;
  logic       w_perr;

  assign w_perr = (^r_shift) ^ r_par;

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 5'd0;
      r_par      <= 1'b0;
      r_data_out <= 5'd0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= 4'd0;
    end else begin
      // The strobe lasts one period whether or not the next edge is enabled.
      r_valid <= 1'b0;
      if (bus.sample_enable) begin
        case (r_state)
          S_IDLE: begin
            if (bus.serial_input) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
              r_busy    <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift[r_bit_cnt] <= bus.serial_input;
            r_bit_cnt          <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd4)
              r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= bus.serial_input;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_data_out <= r_shift;
            r_perr     <= w_perr;
            r_ferr     <= bus.serial_input;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
            if (!w_perr && !bus.serial_input)
              r_count <= r_count + 4'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.data_valid   = r_valid;
  assign bus.parity_error = r_perr;
  assign bus.frame_error  = r_ferr;
  assign bus.busy         = r_busy;
  assign bus.frame_count  = r_count;
endmodule

// File: tb/tb_serial_deframer5.sv
// Directed bench for serial_deframer5: a queue-based frame model is compared
// against the DUT every cycle, plus literal checks at key points of each scenario.
module tb_serial_deframer5;
  logic clk;
  logic clear;
  serial_deframer5_if bus ();

  serial_deframer5 dut (
    .clockpulse (clk),
    .clear      (clear),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember every enabled sample from a start bit onward; eight of them form a frame.
  logic q[$];
  logic [4:0] m_data;
  logic       m_valid, m_perr, m_ferr, m_busy;
  logic [3:0] m_count;

  always @(posedge clk or posedge clear) begin
    if (clear) begin
      q.delete();
      m_data = 5'd0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
      m_busy = 1'b0; m_count = 4'd0;
    end else begin
      m_valid = 1'b0;
      if (bus.sample_enable) begin
        if (q.size() > 0 || bus.serial_input) q.push_back(bus.serial_input);
        if (q.size() == 8) begin
          for (int i = 0; i < 5; i++) m_data[i] = q[i+1];
          m_perr = q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[5] ^ q[6];
          m_ferr = q[7];
          m_valid = 1'b1;
          if (!m_perr && !m_ferr) m_count = (m_count + 4'd1) % 16;
          q.delete();
        end
      end
      m_busy = (q.size() > 0);
    end
  end

  always @(negedge clk) begin
    cmp("data_out",     {3'b0, bus.data_out},     {3'b0, m_data});
    cmp("data_valid",   {7'b0, bus.data_valid},   {7'b0, m_valid});
    cmp("parity_error", {7'b0, bus.parity_error}, {7'b0, m_perr});
    cmp("frame_error",  {7'b0, bus.frame_error},  {7'b0, m_ferr});
    cmp("busy",         {7'b0, bus.busy},         {7'b0, m_busy});
    cmp("frame_count",  {4'b0, bus.frame_count},  {4'b0, m_count});
  end

  task automatic tick(input logic s, input logic e);
    bus.serial_input  = s;
    bus.sample_enable = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [4:0] d, input logic p, input logic stop);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(d[i], 1'b1);
    tick(p, 1'b1);
    tick(stop, 1'b1);
  endtask

  initial begin
    clear = 1'b1;
    bus.serial_input  = 1'b0;
    bus.sample_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_data",  {3'b0, bus.data_out},    8'h00);
    cmp("rst_busy",  {7'b0, bus.busy},        8'h00);
    cmp("rst_count", {4'b0, bus.frame_count}, 8'h00);
    clear = 1'b0;

    repeat (5) tick(1'b0, 1'b1);
    cmp("idle_busy", {7'b0, bus.busy}, 8'h00);

    // Good frame: serial 1,1,0,1,1,0,1,0
    send_frame(5'b01101, 1'b1, 1'b0);
    cmp("good_data",  {3'b0, bus.data_out},     8'h0D);
    cmp("good_valid", {7'b0, bus.data_valid},   8'h01);
    cmp("good_perr",  {7'b0, bus.parity_error}, 8'h00);
    cmp("good_count", {4'b0, bus.frame_count},  8'h01);
    tick(1'b0, 1'b1);
    cmp("good_valid_fall", {7'b0, bus.data_valid}, 8'h00);

    // Parity error
    send_frame(5'b01101, 1'b0, 1'b0);
    cmp("par_data",  {3'b0, bus.data_out},     8'h0D);
    cmp("par_perr",  {7'b0, bus.parity_error}, 8'h01);
    cmp("par_ferr",  {7'b0, bus.frame_error},  8'h00);
    cmp("par_count", {4'b0, bus.frame_count},  8'h01);

    // Frame error followed by idle line
    send_frame(5'b01101, 1'b1, 1'b1);
    cmp("ferr_flag",  {7'b0, bus.frame_error},  8'h01);
    cmp("ferr_perr",  {7'b0, bus.parity_error}, 8'h00);
    cmp("ferr_count", {4'b0, bus.frame_count},  8'h01);
    repeat (10) tick(1'b0, 1'b1);
    cmp("ferr_idle_busy", {7'b0, bus.busy}, 8'h00);

    // Enable gating: each bit held two clocks, enabled only on the first
    begin
      logic [7:0] seq;
      seq = 8'b01011011; // LSB sent first: 1,1,0,1,1,0,1,0
      for (int i = 0; i < 8; i++) begin
        tick(seq[i], 1'b1);
        if (i == 7) begin
          cmp("gate_valid", {7'b0, bus.data_valid}, 8'h01);
          cmp("gate_data",  {3'b0, bus.data_out},   8'h0D);
        end
        tick(seq[i], 1'b0);
      end
      cmp("gate_valid_fall", {7'b0, bus.data_valid},  8'h00);
      cmp("gate_count",      {4'b0, bus.frame_count}, 8'h02);
    end

    // Reset mid-frame after the 4th bit
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    cmp("mid_busy_before", {7'b0, bus.busy}, 8'h01);
    #2 clear = 1'b1;
    #1;
    cmp("mid_rst_data",  {3'b0, bus.data_out},    8'h00);
    cmp("mid_rst_busy",  {7'b0, bus.busy},        8'h00);
    cmp("mid_rst_count", {4'b0, bus.frame_count}, 8'h00);
    @(posedge clk);
    #1 clear = 1'b0;
    send_frame(5'b11000, 1'b0, 1'b0);
    cmp("mid_data",  {3'b0, bus.data_out},    8'h18);
    cmp("mid_valid", {7'b0, bus.data_valid},  8'h01);
    cmp("mid_count", {4'b0, bus.frame_count}, 8'h01);

    // Wrap: 16 back-to-back good frames from a cleared count
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] d;
      d = 5'(i) ^ 5'h15;
      send_frame(d, ^d, 1'b0);
      if (i == 14) cmp("wrap_count15", {4'b0, bus.frame_count}, 8'h0F);
    end
    cmp("wrap_count0", {4'b0, bus.frame_count}, 8'h00);
    cmp("wrap_valid",  {7'b0, bus.data_valid},  8'h01);
    cmp("wrap_data",   {3'b0, bus.data_out},    8'h1A);
    repeat (4) tick(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_deframer5.md
# serial_deframer5

Serial frame receiver that sits directly downstream of the 5-bit right-shift register chain. It consumes the bit stream shifted out of the register's LSB (`signal_q[0]`) and recovers 5-bit data words from framed serial traffic: start bit, 5 data bits LSB-first, even-parity bit, stop bit. Each completed word is presented in parallel with a one-cycle valid strobe, parity and framing error flags, and a running count of good frames.

## Interface
Parameters: none (frame format fixed).

Ports:
- `clockpulse` input 1: sampling clock, rising-edge active.
- `clear` input 1: asynchronous, active-high reset.
- `serial_input` input 1: serial bit stream, normally `signal_q[0]` of the upstream shift register.
- `sample_enable` input 1: when 1, `serial_input` is sampled on this rising edge. When 0, the edge is ignored except for the `data_valid` pulse timing.
- `data_out` output 5: last received word; bit 0 is the first data bit received.
- `data_valid` output 1: one-clock strobe marking frame completion.
- `parity_error` output 1: the last completed frame failed even parity.
- `frame_error` output 1: the last completed frame had stop bit = 1.
- `busy` output 1: 1 whenever the FSM is not in IDLE.
- `frame_count` output 4: count of error-free frames, modulo 16.

## Operation
- The line idles at 0. A sampled 1 in IDLE is a start bit.
- FSM states and transitions:
  - IDLE: on an enabled sample of 1, go to DATA and clear the bit counter.
  - DATA: on each enabled sample, store the bit at position `bit_cnt` (0..4) and increment `bit_cnt`. After bit 4, go to PARITY.
  - PARITY: on an enabled sample, store the parity bit and go to STOP.
  - STOP: on an enabled sample, complete the frame and go to IDLE.
- Frame completion happens on the enabled edge that samples the stop bit:
  - `data_out` ← assembled 5 data bits.
  - `parity_error` ← XOR of the 5 data bits and the parity bit (must be 0 for even parity).
  - `frame_error` ← stop bit value.
  - `data_valid` ← 1.
  - `frame_count` increments only if both error flags are 0, and wraps 15 → 0.
- `data_out`, `parity_error` and `frame_error` hold their values until the next frame completes or `clear` is asserted.
- A frame error does not resynchronise the receiver. The stop-bit sample is consumed, and the next start bit must be a new sampled 1.
- Samples with `sample_enable` = 0 never advance the FSM or counters.

## Timing
- Reset (`clear` = 1, asynchronous):
  - state = IDLE, `bit_cnt` = 0.
  - `data_out` = 5'b00000.
  - `data_valid`, `parity_error`, `frame_error`, `busy` = 0.
  - `frame_count` = 4'h0.
- Reset mid-frame aborts the partial frame with no `data_valid`. Reception resumes from IDLE after release.
- Latency: exactly 8 enabled edges from the start-bit edge to `data_valid`, inclusive. That is the start bit, 5 data bits, parity and stop.
- `data_valid` is high for exactly one `clockpulse` period after the stop edge. It falls on the next rising edge regardless of `sample_enable`.
- `busy` rises the cycle after the start-bit edge and falls the cycle after the stop edge, coincident with `data_valid` rising.
- Back-to-back frames: a start bit sampled on the enabled edge immediately after the stop edge is accepted. There is no idle gap requirement.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Good frame:** enable held 1, serial 1,1,0,1,1,0,1,0 → `data_out` = 5'b01101; `data_valid` pulses once after the 8th edge; both error flags 0; `frame_count` 0 → 1.
- **Parity error:** same frame with parity bit 0 (1,1,0,1,1,0,0,0) → `data_out` = 5'b01101, `parity_error` = 1, `frame_error` = 0, `frame_count` unchanged.
- **Frame error:** good data and parity with stop = 1, then idle 0s → `frame_error` = 1, `data_valid` pulses once; the FSM returns to IDLE with no spurious second frame.
- **Enable gating:** `sample_enable` alternating 1/0 with each bit held for 2 clocks → identical result to the good frame; `data_valid` is still a single 1-clock pulse.
- **Reset mid-frame:** `clear` pulsed after the 4th bit → all outputs 0 immediately; a following good frame with data 5'b11000 (serial 1,0,0,0,1,1,0,0) decodes correctly with `frame_count` = 1.
- **Wrap:** 16 consecutive back-to-back good frames → `frame_count` reads 0 after the 16th `data_valid`; idle 0s alone never assert `busy`.
